// File: rtl/dmem_responder.sv
// dmem_responder
// Data-side memory target for the pipelined RV32 core. It answers the M-stage
// load/store requests by decoding them to a word-addressed data RAM or a small
// MMIO bank (TOHOST, CYCLE_LO, CYCLE_HI snapshot, SCRATCH). Read data comes back
// registered one cycle after the request, lined up with the M->W register.
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   addr          byte address of the request
//   we / re       store / load request (we has priority)
//   be, wdata     byte-lane enables and lane-aligned store data
//   rdata         registered read data, valid the cycle after re
//   tohost        TOHOST register value
//   done          sticky, set by a nonzero TOHOST write
//   err           sticky, set by any access to an unmapped address
module dmem_responder #(
    parameter logic [31:0] DMEM_BASE   = 32'h1000_0000,
    parameter int          DEPTH_WORDS = 4096,
    parameter logic [31:0] MMIO_BASE   = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic        re,
    input  logic [3:0]  be,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [31:0] tohost,
    output logic        done,
    output logic        err
);
    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] DMEM_SPAN = 32'(DEPTH_WORDS * 4);

    // Address decode. The RAM range check uses the offset from the base so
    // that a window ending exactly at 2^32 does not overflow.
    logic [31:0]   ram_off;
    logic          ram_hit;
    logic          mmio_hit;
    logic          unmapped;
    logic [1:0]    mmio_off;
    logic [AW-1:0] ram_idx;
    logic          rd;

    assign ram_off  = addr - DMEM_BASE;
    assign ram_hit  = (addr >= DMEM_BASE) && (ram_off < DMEM_SPAN);
    assign mmio_hit = (addr[31:4] == MMIO_BASE[31:4]);
    assign unmapped = !(ram_hit || mmio_hit);
    assign mmio_off = addr[3:2];
    assign ram_idx  = ram_off[AW+1:2];
    assign rd       = !we && re;

    // State
    logic [63:0] cycle_q,     cycle_d;
    logic [31:0] snap_q,      snap_d;
    logic [31:0] scratch_q,   scratch_d;
    logic [31:0] tohost_q,    tohost_d;
    logic        done_q,      done_d;
    logic        err_q,       err_d;
    logic [31:0] mmio_dout_q, mmio_dout_d;
    logic        src_ram_q,   src_ram_d;   // last read came from the RAM
    logic [31:0] scratch_wr;
    logic [31:0] ram_dout;

    // Data RAM split into one byte-wide array per lane so each lane has its
    // own write enable. Read port is registered and only advances on a RAM
    // read, which gives the hold-between-loads behaviour for free.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [DEPTH_WORDS];
            logic [7:0] dout_q;

            always_ff @(posedge clk) begin
                if (!rst && we && ram_hit && be[gi]) begin
                    mem[ram_idx] <= wdata[8*gi +: 8];
                end
                if (!rst && rd && ram_hit) begin
                    dout_q <= mem[ram_idx];
                end
            end

            assign ram_dout[8*gi +: 8]   = dout_q;
            assign scratch_wr[8*gi +: 8] = be[gi] ? wdata[8*gi +: 8] : scratch_q[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        cycle_d     = cycle_q + 64'd1;
        snap_d      = snap_q;
        scratch_d   = scratch_q;
        tohost_d    = tohost_q;
        done_d      = done_q;
        err_d       = err_q;
        mmio_dout_d = mmio_dout_q;
        src_ram_d   = src_ram_q;

        if ((we || re) && unmapped) begin
            err_d = 1'b1;
        end

        if (we && mmio_hit) begin
            case (mmio_off)
                2'd0: begin
                    // TOHOST ignores be and locks once a nonzero value lands.
                    if (!done_q) begin
                        tohost_d = wdata;
                        if (wdata != 32'd0) begin
                            done_d = 1'b1;
                        end
                    end
                end
                2'd3:    scratch_d = scratch_wr;
                default: ;  // cycle counter words are read-only
            endcase
        end

        if (rd) begin
            if (ram_hit) begin
                src_ram_d = 1'b1;
            end else begin
                src_ram_d   = 1'b0;
                mmio_dout_d = 32'd0;
                if (mmio_hit) begin
                    case (mmio_off)
                        2'd0: mmio_dout_d = tohost_q;
                        2'd1: begin
                            // Snapshot the high half so a following CYCLE_HI
                            // read pairs coherently with this low half.
                            mmio_dout_d = cycle_q[31:0];
                            snap_d      = cycle_q[63:32];
                        end
                        2'd2:    mmio_dout_d = snap_q;
                        default: mmio_dout_d = scratch_q;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q     <= 64'd0;
            snap_q      <= 32'd0;
            scratch_q   <= 32'd0;
            tohost_q    <= 32'd0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            mmio_dout_q <= 32'd0;
            src_ram_q   <= 1'b0;
        end else begin
            cycle_q     <= cycle_d;
            snap_q      <= snap_d;
            scratch_q   <= scratch_d;
            tohost_q    <= tohost_d;
            done_q      <= done_d;
            err_q       <= err_d;
            mmio_dout_q <= mmio_dout_d;
            src_ram_q   <= src_ram_d;
        end
    end

    assign rdata  = src_ram_q ? ram_dout : mmio_dout_q;
    assign tohost = tohost_q;
    assign done   = done_q;
    assign err    = err_q;

endmodule
